task3_circle_top: RTL and testbench

// - Board-level top for the circle exercise on the 160x120, 3-bit-colour VGA framebuffer.
// - After reset, optionally clears the screen to black, then draws one circle outline.
// - Uses the midpoint (Bresenham) algorithm and plots one pixel per clock.
// - Raises a done flag on LEDR[0], then idles until the next reset.

---
 rtl/task3_pkg.sv | 23 ++
 rtl/task3_circle_top_circle_draw.sv | 98 +++++++++
 rtl/vga_adapter.sv | 88 ++++++++
 rtl/task3_circle_top.sv | 191 +++++++++++++++++++
 tb/tb_task3_circle_top.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/task3_pkg.sv
// task3_pkg: shared types and constants for the circle-drawing exercise.
// - Framebuffer geometry (160x120, 3-bit colour).
// - Drawing phase enumeration used by the top-level sequencer.
// - Coordinate types and a clipping helper for signed 10-bit coordinates.
package task3_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {CLEAR, INIT, OCTANT, DONE} state_t;

    typedef logic [7:0] xcoord_t;
    typedef logic [6:0] ycoord_t;

    // Centre +/- offset arithmetic can leave the screen on either side,
    // so intermediate coordinates are carried signed with two spare bits.
    typedef logic signed [9:0] coord_t;

    function automatic logic on_screen(input coord_t x, input coord_t y);
        return !x[9] && (x < coord_t'(SCREEN_W)) && !y[9] && (y < coord_t'(SCREEN_H));
    endfunction

endpackage

// File: rtl/task3_circle_top_circle_draw.sv
// circle_draw: midpoint circle engine, one octant point per clock.
// Ports:
//   clk, srst          clock and synchronous active-high reset
//   start              load the first iteration (oy=0, ox=RADIUS)
//   done               high during the final octant cycle of the final iteration
//   x, y, colour, plot current point; plot is low for off-screen points
// Points are presented combinationally from the iteration registers; the
// caller registers them.
module circle_draw
    import task3_pkg::*;
#(
    parameter int         CENTRE_X = 80,
    parameter int         CENTRE_Y = 60,
    parameter int         RADIUS   = 40,
    parameter logic [2:0] COLOUR   = 3'b010
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       start,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam coord_t CX = coord_t'(CENTRE_X);
    localparam coord_t CY = coord_t'(CENTRE_Y);

    logic       busy_reg;
    logic [2:0] oct_reg;
    coord_t     ox_reg, oy_reg, crit_reg;

    coord_t     px, py;
    coord_t     oy_step, ox_step, crit_step;
    logic       crit_nonpos, last_iter;

    always_comb begin
        px = CX;
        py = CY;
        case (oct_reg)
            3'd0: begin px = CX + ox_reg; py = CY + oy_reg; end
            3'd1: begin px = CX + oy_reg; py = CY + ox_reg; end
            3'd2: begin px = CX - ox_reg; py = CY + oy_reg; end
            3'd3: begin px = CX - oy_reg; py = CY + ox_reg; end
            3'd4: begin px = CX - ox_reg; py = CY - oy_reg; end
            3'd5: begin px = CX - oy_reg; py = CY - ox_reg; end
            3'd6: begin px = CX + ox_reg; py = CY - oy_reg; end
            default: begin px = CX + oy_reg; py = CY - ox_reg; end
        endcase
    end

    // Decision-variable update, evaluated with the already-stepped oy/ox.
    always_comb begin
        crit_nonpos = crit_reg[9] || (crit_reg == '0);
        oy_step     = oy_reg + 10'sd1;
        ox_step     = crit_nonpos ? ox_reg : ox_reg - 10'sd1;
        if (crit_nonpos) begin
            crit_step = crit_reg + (oy_step <<< 1) + 10'sd1;
        end else begin
            crit_step = crit_reg + ((oy_step - ox_step) <<< 1) + 10'sd1;
        end
        last_iter = (oct_reg == 3'd7) && (oy_step > ox_step);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            busy_reg <= 1'b0;
            oct_reg  <= '0;
            ox_reg   <= '0;
            oy_reg   <= '0;
            crit_reg <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            oct_reg  <= '0;
            ox_reg   <= coord_t'(RADIUS);
            oy_reg   <= '0;
            crit_reg <= coord_t'(1 - RADIUS);
        end else if (busy_reg) begin
            oct_reg <= oct_reg + 3'd1;
            if (oct_reg == 3'd7) begin
                oy_reg   <= oy_step;
                ox_reg   <= ox_step;
                crit_reg <= crit_step;
                if (last_iter) begin
                    busy_reg <= 1'b0;
                end
            end
        end
    end

    assign done   = busy_reg && last_iter;
    assign x      = px[7:0];
    assign y      = py[6:0];
    assign colour = COLOUR;
    assign plot   = busy_reg && on_screen(px, py);

endmodule

// File: rtl/vga_adapter.sv
// vga_adapter: framebuffer plus 640x480 raster scan-out.
// Ports:
//   resetn          synchronous, active-low reset
//   clock           system clock; the pixel clock is clock/2
//   colour/x/y/plot pixel write port (one pixel per cycle while plot=1)
//   VGA_R/G/B       8-bit colour channels, each driven from one colour bit
//   VGA_HS/VGA_VS   active-low sync pulses
//   VGA_CLK         pixel clock
// Each framebuffer pixel is replicated into a square block on the display.
module vga_adapter #(
    parameter RESOLUTION = "160x120"
) (
    input  logic       resetn,
    input  logic       clock,
    input  logic [2:0] colour,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic       plot,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_CLK
);

    localparam int FB_W  = (RESOLUTION == "320x240") ? 320 : 160;
    localparam int FB_H  = (FB_W * 3) / 4;
    localparam int SHIFT = (FB_W == 320) ? 1 : 2;
    localparam int AW    = $clog2(FB_W * FB_H);

    logic [2:0]    fb_mem [0:FB_W*FB_H-1];
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_data_reg;

    logic          pix_en_reg;
    logic [9:0]    h_cnt_reg;
    logic [9:0]    v_cnt_reg;
    logic          visible;
    logic          vis_d_reg;
    logic          hs_reg;
    logic          vs_reg;

    assign wr_addr = AW'(int'(y) * FB_W + int'(x));
    assign visible = (h_cnt_reg < 10'd640) && (v_cnt_reg < 10'd480);
    assign rd_addr = visible ? AW'(int'(v_cnt_reg >> SHIFT) * FB_W + int'(h_cnt_reg >> SHIFT)) : '0;

    always_ff @(posedge clock) begin
        if (plot && (int'(x) < FB_W) && (int'(y) < FB_H)) begin
            fb_mem[wr_addr] <= colour;
        end
        rd_data_reg <= fb_mem[rd_addr];
    end

    // Sync and blanking are delayed one stage to line up with the RAM read.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pix_en_reg <= 1'b0;
            h_cnt_reg  <= '0;
            v_cnt_reg  <= '0;
            vis_d_reg  <= 1'b0;
            hs_reg     <= 1'b1;
            vs_reg     <= 1'b1;
        end else begin
            pix_en_reg <= ~pix_en_reg;
            vis_d_reg  <= visible;
            hs_reg     <= !((h_cnt_reg >= 10'd656) && (h_cnt_reg < 10'd752));
            vs_reg     <= !((v_cnt_reg >= 10'd490) && (v_cnt_reg < 10'd492));
            if (pix_en_reg) begin
                if (h_cnt_reg == 10'd799) begin
                    h_cnt_reg <= '0;
                    v_cnt_reg <= (v_cnt_reg == 10'd524) ? 10'd0 : v_cnt_reg + 10'd1;
                end else begin
                    h_cnt_reg <= h_cnt_reg + 10'd1;
                end
            end
        end
    end

    assign VGA_R   = vis_d_reg ? {8{rd_data_reg[2]}} : 8'd0;
    assign VGA_G   = vis_d_reg ? {8{rd_data_reg[1]}} : 8'd0;
    assign VGA_B   = vis_d_reg ? {8{rd_data_reg[0]}} : 8'd0;
    assign VGA_HS  = hs_reg;
    assign VGA_VS  = vs_reg;
    assign VGA_CLK = pix_en_reg;

endmodule

// File: rtl/task3_circle_top.sv
// task3_circle_top: board top that (optionally) clears the 160x120 screen
// and then draws one circle outline, one pixel per clock.
// Ports:
//   CLOCK_50              system clock
//   KEY[3]                synchronous active-high reset; KEY[2:0], SW unused
//   LEDR[0]               done flag; LEDR[9:1] tied low
//   HEX0..HEX5            all segments off
//   VGA_R/G/B/HS/VS/CLK   from the internal vga_adapter
//   VGA_X/Y/COLOUR/PLOT   registered pixel write stream
// Build option: define CLEAR_SCREEN_EN to include the black clear pass
// (19200 column-major plot cycles) ahead of the circle.
module task3_circle_top
    import task3_pkg::*;
#(
    parameter int         CENTRE_X = 80,
    parameter int         CENTRE_Y = 60,
    parameter int         RADIUS   = 40,
    parameter logic [2:0] COLOUR   = 3'b010
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_CLK,
    output logic [7:0] VGA_X,
    output logic [6:0] VGA_Y,
    output logic [2:0] VGA_COLOUR,
    output logic       VGA_PLOT
);

`ifdef CLEAR_SCREEN_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = INIT;
`endif

    logic    clk;
    logic    srst;
    logic    unused_inputs;

    state_t  state_reg, state_next;
    xcoord_t clr_x_reg, clr_x_next;
    ycoord_t clr_y_reg, clr_y_next;
    xcoord_t x_reg, x_next;
    ycoord_t y_reg, y_next;
    logic [2:0] colour_reg, colour_next;
    logic    plot_reg, plot_next;
    logic    done_reg, done_next;

    logic       eng_start, eng_done, eng_plot;
    logic [7:0] eng_x;
    logic [6:0] eng_y;
    logic [2:0] eng_colour;

    assign clk           = CLOCK_50;
    assign srst          = KEY[3];
    assign unused_inputs = ^{KEY[2:0], SW};

    circle_draw #(
        .CENTRE_X (CENTRE_X),
        .CENTRE_Y (CENTRE_Y),
        .RADIUS   (RADIUS),
        .COLOUR   (COLOUR)
    ) u_circle_draw (
        .clk    (clk),
        .srst   (srst),
        .start  (eng_start),
        .done   (eng_done),
        .x      (eng_x),
        .y      (eng_y),
        .colour (eng_colour),
        .plot   (eng_plot)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg  <= RESET_STATE;
            clr_x_reg  <= '0;
            clr_y_reg  <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= '0;
            plot_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            clr_x_reg  <= clr_x_next;
            clr_y_reg  <= clr_y_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            colour_reg <= colour_next;
            plot_reg   <= plot_next;
            done_reg   <= done_next;
        end
    end

    // The pixel stream is registered here, so whatever is selected in a
    // state appears on the VGA_* outputs one cycle later.
    always_comb begin
        state_next  = state_reg;
        clr_x_next  = clr_x_reg;
        clr_y_next  = clr_y_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        colour_next = colour_reg;
        plot_next   = 1'b0;
        done_next   = done_reg;
        eng_start   = 1'b0;
        case (state_reg)
            CLEAR: begin
                plot_next   = 1'b1;
                x_next      = clr_x_reg;
                y_next      = clr_y_reg;
                colour_next = 3'b000;
                if (clr_y_reg == ycoord_t'(SCREEN_H - 1)) begin
                    clr_y_next = '0;
                    if (clr_x_reg == xcoord_t'(SCREEN_W - 1)) begin
                        clr_x_next = '0;
                        state_next = INIT;
                    end else begin
                        clr_x_next = clr_x_reg + 8'd1;
                    end
                end else begin
                    clr_y_next = clr_y_reg + 7'd1;
                end
            end
            INIT: begin
                eng_start  = 1'b1;
                state_next = OCTANT;
            end
            OCTANT: begin
                plot_next   = eng_plot;
                x_next      = eng_x;
                y_next      = eng_y;
                colour_next = eng_colour;
                // Done is raised alongside the final octant point.
                if (eng_done) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next = 1'b1;
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    vga_adapter #(
        .RESOLUTION ("160x120")
    ) u_vga_adapter (
        .resetn  (~srst),
        .clock   (clk),
        .colour  (colour_reg),
        .x       (x_reg),
        .y       (y_reg),
        .plot    (plot_reg),
        .VGA_R   (VGA_R),
        .VGA_G   (VGA_G),
        .VGA_B   (VGA_B),
        .VGA_HS  (VGA_HS),
        .VGA_VS  (VGA_VS),
        .VGA_CLK (VGA_CLK)
    );

    assign VGA_X      = x_reg;
    assign VGA_Y      = y_reg;
    assign VGA_COLOUR = colour_reg;
    assign VGA_PLOT   = plot_reg;
    assign LEDR       = {9'd0, done_reg};
    assign HEX0       = 7'h7F;
    assign HEX1       = 7'h7F;
    assign HEX2       = 7'h7F;
    assign HEX3       = 7'h7F;
    assign HEX4       = 7'h7F;
    assign HEX5       = 7'h7F;

endmodule

// File: tb/tb_task3_circle_top.sv
// Bench for task3_circle_top: default-parameter instance plus a second
// instance centred at x=5 so part of its circle is clipped. Expected pixel
// streams come from a list-building midpoint-circle model.
`timescale 1ns/1ps
module tb_task3_circle_top;

`ifdef CLEAR_SCREEN_EN
    localparam int CLR = 19200;
`else
    localparam int CLR = 0;
`endif
    localparam int R       = 40;
    localparam int COL     = 2;
    localparam int DONE_C  = CLR + 1 + 232;
    localparam int IDLE_CY = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] key;
    logic [9:0] sw;

    logic [9:0] m_ledr, e_ledr;
    logic [6:0] m_h0, m_h1, m_h2, m_h3, m_h4, m_h5;
    logic [6:0] e_h0, e_h1, e_h2, e_h3, e_h4, e_h5;
    logic [7:0] m_r, m_g, m_b, e_r, e_g, e_b;
    logic       m_hs, m_vs, m_vclk, e_hs, e_vs, e_vclk;
    logic [7:0] m_x, e_x;
    logic [6:0] m_y, e_y;
    logic [2:0] m_col, e_col;
    logic       m_plot, e_plot;

    task3_circle_top dut (
        .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(m_ledr),
        .HEX0(m_h0), .HEX1(m_h1), .HEX2(m_h2), .HEX3(m_h3), .HEX4(m_h4), .HEX5(m_h5),
        .VGA_R(m_r), .VGA_G(m_g), .VGA_B(m_b), .VGA_HS(m_hs), .VGA_VS(m_vs), .VGA_CLK(m_vclk),
        .VGA_X(m_x), .VGA_Y(m_y), .VGA_COLOUR(m_col), .VGA_PLOT(m_plot)
    );

    task3_circle_top #(.CENTRE_X(5), .CENTRE_Y(60), .RADIUS(R)) dut_edge (
        .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(e_ledr),
        .HEX0(e_h0), .HEX1(e_h1), .HEX2(e_h2), .HEX3(e_h3), .HEX4(e_h4), .HEX5(e_h5),
        .VGA_R(e_r), .VGA_G(e_g), .VGA_B(e_b), .VGA_HS(e_hs), .VGA_VS(e_vs), .VGA_CLK(e_vclk),
        .VGA_X(e_x), .VGA_Y(e_y), .VGA_COLOUR(e_col), .VGA_PLOT(e_plot)
    );

    typedef struct {
        int x;
        int y;
        bit on;
    } pt_t;

    pt_t q_main[$];
    pt_t q_edge[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Walk one octant's arc with the midpoint rule and mirror each step
    // into all eight octants, in drawing order.
    task automatic build_model(input int cx, input int cy, input int r, input bit to_edge);
        int ox, oy, crit;
        int px[8];
        int py[8];
        pt_t p;
        oy = 0;
        ox = r;
        crit = 1 - r;
        while (oy <= ox) begin
            px = '{cx + ox, cx + oy, cx - ox, cx - oy, cx - ox, cx - oy, cx + ox, cx + oy};
            py = '{cy + oy, cy + ox, cy + oy, cy + ox, cy - oy, cy - ox, cy - oy, cy - ox};
            for (int k = 0; k < 8; k++) begin
                p.x  = px[k];
                p.y  = py[k];
                p.on = (px[k] >= 0) && (px[k] < 160) && (py[k] >= 0) && (py[k] < 120);
                if (to_edge) q_edge.push_back(p);
                else         q_main.push_back(p);
            end
            oy++;
            if (crit <= 0) begin
                crit += 2 * oy + 1;
            end else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end
    endtask

    // Expected pixel stream at cycle c after reset release (c=1 is the
    // first cycle after the release edge).
    function automatic void exp_at(input bit from_edge, input int c,
                                   output bit ep, output int ex, output int ey, output int ecol);
        int n;
        pt_t p;
        n = from_edge ? q_edge.size() : q_main.size();
        ep = 1'b0; ex = 0; ey = 0; ecol = 0;
        if (c >= 1 && c <= CLR) begin
            ep = 1'b1;
            ex = (c - 1) / 120;
            ey = (c - 1) % 120;
        end else if (c >= CLR + 2 && c <= CLR + 1 + n) begin
            p = from_edge ? q_edge[c - CLR - 2] : q_main[c - CLR - 2];
            ep = p.on; ex = p.x; ey = p.y; ecol = COL;
        end
    endfunction

    task automatic randomize_unused();
        key[2:0] = 3'($urandom);
        sw       = 10'($urandom);
    endtask

    task automatic test_reset();
        logic [41:0] hex_all;
        key = 4'b1000;
        randomize_unused();
        repeat (2) @(posedge clk);
        #1;
        hex_all = {m_h5, m_h4, m_h3, m_h2, m_h1, m_h0};
        n_tests++; if (m_plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot: got %0d expected 0", m_plot); end
        n_tests++; if (m_x !== 8'd0) begin n_fail++; $display("FAIL reset_x: got %0d expected 0", m_x); end
        n_tests++; if (m_y !== 7'd0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", m_y); end
        n_tests++; if (m_col !== 3'd0) begin n_fail++; $display("FAIL reset_colour: got %0d expected 0", m_col); end
        n_tests++; if (m_ledr !== 10'd0) begin n_fail++; $display("FAIL reset_ledr: got %h expected 000", m_ledr); end
        n_tests++; if (e_ledr !== 10'd0 || e_plot !== 1'b0) begin n_fail++; $display("FAIL reset_edge: ledr %h plot %0d expected 000/0", e_ledr, e_plot); end
        n_tests++; if (hex_all !== {6{7'h7F}}) begin n_fail++; $display("FAIL reset_hex: got %h expected all 7f", hex_all); end
    endtask

    task automatic test_full_draw();
        int fx[6] = '{120, 80, 40, 80, 40, 80};
        int fy[6] = '{60, 100, 60, 100, 60, 20};
        bit ep; int ex, ey, ecol;
        int err_main = 0, err_edge = 0, first_bad = -1;
        int plots = 0, post_plots = 0, edge_oob = 0, hi_ledr = 0;
        int done_m = -1, done_e = -1;
        key[3] = 1'b0;
        for (int c = 1; c <= DONE_C + IDLE_CY; c++) begin
            @(posedge clk);
            #1;
            randomize_unused();
            exp_at(1'b0, c, ep, ex, ey, ecol);
            if (m_plot !== ep || (ep && (int'(m_x) != ex || int'(m_y) != ey || int'(m_col) != ecol))) begin
                err_main++;
                if (first_bad < 0) first_bad = c;
            end
            exp_at(1'b1, c, ep, ex, ey, ecol);
            if (e_plot !== ep || (ep && (int'(e_x) != ex || int'(e_y) != ey || int'(e_col) != ecol))) err_edge++;
            if (e_plot === 1'b1 && (e_x > 8'd159 || e_y > 7'd119)) edge_oob++;
            if (m_plot === 1'b1) plots++;
            if (c > DONE_C && m_plot !== 1'b0) post_plots++;
            if (m_ledr[9:1] !== 9'd0) hi_ledr++;
            if (done_m < 0 && m_ledr[0] === 1'b1) done_m = c;
            if (done_e < 0 && e_ledr[0] === 1'b1) done_e = c;
`ifdef CLEAR_SCREEN_EN
            if (c == 1) begin
                n_tests++; if (m_plot !== 1'b1 || m_x !== 8'd0 || m_y !== 7'd0 || m_col !== 3'd0) begin n_fail++; $display("FAIL clear_first: got plot %0d (%0d,%0d) col %0d expected 1 (0,0) col 0", m_plot, m_x, m_y, m_col); end
            end
            if (c == 120) begin
                n_tests++; if (m_plot !== 1'b1 || m_x !== 8'd0 || m_y !== 7'd119) begin n_fail++; $display("FAIL clear_col0_end: got plot %0d (%0d,%0d) expected 1 (0,119)", m_plot, m_x, m_y); end
            end
            if (c == 121) begin
                n_tests++; if (m_plot !== 1'b1 || m_x !== 8'd1 || m_y !== 7'd0) begin n_fail++; $display("FAIL clear_col1: got plot %0d (%0d,%0d) expected 1 (1,0)", m_plot, m_x, m_y); end
            end
            if (c == CLR) begin
                n_tests++; if (m_plot !== 1'b1 || m_x !== 8'd159 || m_y !== 7'd119) begin n_fail++; $display("FAIL clear_last: got plot %0d (%0d,%0d) expected 1 (159,119)", m_plot, m_x, m_y); end
            end
`endif
            if (c == CLR + 1) begin
                n_tests++; if (m_plot !== 1'b0) begin n_fail++; $display("FAIL init_plot: got %0d expected 0", m_plot); end
            end
            if (c >= CLR + 2 && c <= CLR + 7) begin
                n_tests++;
                if (m_plot !== 1'b1 || int'(m_x) != fx[c - CLR - 2] || int'(m_y) != fy[c - CLR - 2] || m_col !== 3'b010) begin
                    n_fail++;
                    $display("FAIL circle_pt%0d: got plot %0d (%0d,%0d) col %0d expected 1 (%0d,%0d) col 2",
                             c - CLR - 2, m_plot, m_x, m_y, m_col, fx[c - CLR - 2], fy[c - CLR - 2]);
                end
            end
        end
        n_tests++; if (err_main != 0) begin n_fail++; $display("FAIL main_trace: got %0d bad cycles (first %0d) expected 0", err_main, first_bad); end
        n_tests++; if (err_edge != 0) begin n_fail++; $display("FAIL edge_trace: got %0d bad cycles expected 0", err_edge); end
        n_tests++; if (edge_oob != 0) begin n_fail++; $display("FAIL edge_clip: got %0d off-screen plots expected 0", edge_oob); end
        n_tests++; if (done_m != DONE_C) begin n_fail++; $display("FAIL done_cycle: got %0d expected %0d", done_m, DONE_C); end
        n_tests++; if (done_e != DONE_C) begin n_fail++; $display("FAIL edge_done_cycle: got %0d expected %0d", done_e, DONE_C); end
        n_tests++; if (plots != CLR + 232) begin n_fail++; $display("FAIL plot_count: got %0d expected %0d", plots, CLR + 232); end
        n_tests++; if (post_plots != 0) begin n_fail++; $display("FAIL idle_after_done: got %0d plot cycles expected 0", post_plots); end
        n_tests++; if (hi_ledr != 0) begin n_fail++; $display("FAIL ledr_upper: got %0d nonzero cycles expected 0", hi_ledr); end
    endtask

    task automatic test_mid_reset();
        bit ep; int ex, ey, ecol;
        int rc, err = 0, done_m = -1;
        rc = (CLR > 0) ? int'($urandom_range(4000, 6000)) : int'($urandom_range(2, 200));
        key[3] = 1'b1;
        @(posedge clk);
        #1;
        key[3] = 1'b0;
        repeat (rc) @(posedge clk);
        #1;
        key[3] = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (m_plot !== 1'b0 || m_ledr !== 10'd0 || m_x !== 8'd0 || m_y !== 7'd0) begin n_fail++; $display("FAIL midreset_state (at %0d): got plot %0d ledr %h (%0d,%0d) expected 0 000 (0,0)", rc, m_plot, m_ledr, m_x, m_y); end
        key[3] = 1'b0;
        for (int c = 1; c <= DONE_C + 5; c++) begin
            @(posedge clk);
            #1;
            randomize_unused();
            exp_at(1'b0, c, ep, ex, ey, ecol);
            if (m_plot !== ep || (ep && (int'(m_x) != ex || int'(m_y) != ey || int'(m_col) != ecol))) err++;
            if (done_m < 0 && m_ledr[0] === 1'b1) done_m = c;
            if (c == 1) begin
                exp_at(1'b0, 1, ep, ex, ey, ecol);
                n_tests++; if (m_plot !== ep || m_ledr[0] !== 1'b0 || (ep && (int'(m_x) != ex || int'(m_y) != ey))) begin n_fail++; $display("FAIL restart_first: got plot %0d ledr0 %0d (%0d,%0d) expected %0d 0 (%0d,%0d)", m_plot, m_ledr[0], m_x, m_y, ep, ex, ey); end
            end
        end
        n_tests++; if (err != 0) begin n_fail++; $display("FAIL restart_trace: got %0d bad cycles expected 0", err); end
        n_tests++; if (done_m != DONE_C) begin n_fail++; $display("FAIL restart_done: got %0d expected %0d", done_m, DONE_C); end
    endtask

    initial begin
        key = 4'b1000;
        sw  = '0;
        build_model(80, 60, R, 1'b0);
        build_model(5, 60, R, 1'b1);
        test_reset();
        test_full_draw();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
